// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared widths, FSM state encoding and the ciphertext range check.
package decrypt_pkg;
    localparam int MSG_W = 12;
    localparam int KEY_W = 24;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, DRAIN} state_t;

    // A word is only decryptable when it lies strictly below a non-zero modulus.
    function automatic logic msg_ok(input logic [MSG_W-1:0] m, input logic [KEY_W-1:0] n);
        return n != '0 && KEY_W'(m) < n;
    endfunction
endpackage

// File: rtl/decrypt_sequencer_if.sv
// decrypt_sequencer_if: config, ciphertext/plaintext streams and modExp engine handshake.
interface decrypt_sequencer_if;
    logic                         cfg_load;
    logic [decrypt_pkg::KEY_W-1:0] key_in;
    logic [decrypt_pkg::KEY_W-1:0] n_in;
    logic                         ct_valid;
    logic [decrypt_pkg::MSG_W-1:0] ct_data;
    logic                         ct_ready;
    logic [decrypt_pkg::MSG_W-1:0] exp_msg;
    logic [decrypt_pkg::KEY_W-1:0] exp_key;
    logic [decrypt_pkg::KEY_W-1:0] exp_n;
    logic                         exp_start;
    logic [decrypt_pkg::MSG_W-1:0] exp_msg_out;
    logic                         exp_fins;
    logic                         pt_valid;
    logic [decrypt_pkg::MSG_W-1:0] pt_data;
    logic                         pt_ready;
    logic                         busy;
    logic                         err;

    modport slave (
        input  cfg_load, key_in, n_in, ct_valid, ct_data, exp_msg_out, exp_fins, pt_ready,
        output ct_ready, exp_msg, exp_key, exp_n, exp_start, pt_valid, pt_data, busy, err
    );
    modport master (
        output cfg_load, key_in, n_in, ct_valid, ct_data, exp_msg_out, exp_fins, pt_ready,
        input  ct_ready, exp_msg, exp_key, exp_n, exp_start, pt_valid, pt_data, busy, err
    );
endinterface

// File: rtl/ct_fifo.sv
// ct_fifo: power-of-two ciphertext FIFO; extra pointer bit separates full from empty.
module ct_fifo import decrypt_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [MSG_W-1:0] din,
    output logic [MSG_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [MSG_W-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;

    assign empty = wptr == rptr;
    assign full  = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/decrypt_sequencer.sv
// decrypt_sequencer: feeds buffered ciphertext words one at a time to an external
// modExp engine and returns the plaintext, dropping out-of-range words and hung operations.
module decrypt_sequencer import decrypt_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 65535
) (
    input logic                clk,
    input logic                rst,
    decrypt_sequencer_if.slave bus
);
    state_t           state, state_nx;
    logic [15:0]      cnt;
    logic [MSG_W-1:0] head, msg_q, pt_q;
    logic [KEY_W-1:0] key_q, n_q;
    logic             full, empty, pop, push, drop, tmo, err_q;

    assign pop  = state == LOAD;
    assign push = bus.ct_valid && bus.ct_ready;
    assign drop = pop && !msg_ok(head, n_q);
    assign tmo  = state == RUN && !bus.exp_fins && cnt == 16'(TIMEOUT - 1);

    ct_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.ct_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = empty ? IDLE : LOAD;
            LOAD:    state_nx = drop ? IDLE : RUN;
            RUN:     state_nx = bus.exp_fins ? HOLD : tmo ? DRAIN : RUN;
            HOLD:    state_nx = bus.pt_ready ? DRAIN : HOLD;
            DRAIN:   state_nx = bus.exp_fins ? DRAIN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            msg_q <= '0;
            key_q <= '0;
            n_q   <= '0;
            pt_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= state == RUN ? cnt + 16'd1 : '0;
            err_q <= drop || tmo;
            if (pop) msg_q <= head;
            if (state == IDLE && bus.cfg_load) begin
                key_q <= bus.key_in;
                n_q   <= bus.n_in;
            end
            if (state == RUN && bus.exp_fins) pt_q <= bus.exp_msg_out;
        end
    end

    // A full FIFO still accepts a word in the cycle it gives one up.
    assign bus.ct_ready  = !full || pop;
    assign bus.exp_msg   = msg_q;
    assign bus.exp_key   = key_q;
    assign bus.exp_n     = n_q;
    assign bus.exp_start = state == RUN;
    assign bus.pt_valid  = state == HOLD;
    assign bus.pt_data   = pt_q;
    assign bus.busy      = state != IDLE;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_decrypt_sequencer.sv
// tb_decrypt_sequencer: directed vectors against an RSA modExp engine model (n=143, d=103).
module tb_decrypt_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic stall = 1'b0;
    logic hold  = 1'b0;

    decrypt_sequencer_if b();

    decrypt_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] ct;
        logic        drop;
        logic [11:0] pt;
    } vec_t;

    function automatic logic [11:0] modexp(logic [11:0] m, logic [23:0] d, logic [23:0] n);
        logic [47:0] r, x;
        if (n == 0) return 12'd0;
        r = 48'd1;
        x = 48'(m) % 48'(n);
        for (int i = 0; i < 24; i++) begin
            if (d[i]) r = (r * x) % 48'(n);
            x = (x * x) % 48'(n);
        end
        return r[11:0];
    endfunction

    initial begin
        int ec;
        b.exp_fins = 1'b0;
        b.exp_msg_out = '0;
        ec = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                b.exp_fins = 1'b0;
                ec = 0;
            end else if (b.exp_fins) begin
                if (!hold && !b.exp_start) b.exp_fins = 1'b0;
            end else if (b.exp_start && !stall) begin
                if (ec == 2) begin
                    b.exp_msg_out = modexp(b.exp_msg, b.exp_key, b.exp_n);
                    b.exp_fins = 1'b1;
                    ec = 0;
                end else ec++;
            end else ec = 0;
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(string nm);
        chk({nm, "_flags"}, {b.ct_ready, b.exp_start, b.pt_valid, b.err, b.busy}, 5'b10000);
        chk({nm, "_regs"}, {b.exp_msg, b.exp_key, b.exp_n, b.pt_data}, '0);
    endtask

    task automatic push(logic [11:0] w);
        int n = 0;
        b.ct_valid = 1'b1;
        b.ct_data = w;
        while (!b.ct_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", b.ct_ready, 1);
        @(negedge clk);
        b.ct_valid = 1'b0;
    endtask

    task automatic get(logic [11:0] want, string nm);
        int n = 0;
        while (!b.pt_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, b.pt_valid, 1);
        chk(nm, b.pt_data, want);
        b.pt_ready = 1'b1;
        @(negedge clk);
        b.pt_ready = 1'b0;
    endtask

    task automatic expect_drop(string nm);
        int ec = 0;
        int ps = 0;
        repeat (8) begin
            @(negedge clk);
            ec += int'(b.err);
            ps += int'(b.pt_valid);
        end
        chk({nm, "_errlen"}, ec, 1);
        chk({nm, "_nopt"}, ps, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[9];
        int   n, bad, acc, run_n, ps;
        v[0] = '{12'd48, 1'b0, 12'd9};
        v[1] = '{12'd143, 1'b1, 12'd0};
        v[2] = '{12'd128, 1'b0, 12'd2};
        v[3] = '{12'd150, 1'b1, 12'd0};
        v[4] = '{12'd42, 1'b0, 12'd3};
        v[5] = '{12'd0, 1'b0, 12'd0};
        v[6] = '{12'd4095, 1'b1, 12'd0};
        v[7] = '{12'd142, 1'b0, 12'd142};
        v[8] = '{12'd1, 1'b0, 12'd1};
        b.cfg_load = 1'b0;
        b.key_in = '0;
        b.n_in = '0;
        b.ct_valid = 1'b0;
        b.ct_data = '0;
        b.pt_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        @(negedge clk);
        push(12'd5);
        expect_drop("n_zero");
        b.cfg_load = 1'b1;
        b.key_in = 24'd103;
        b.n_in = 24'd143;
        @(negedge clk);
        b.cfg_load = 1'b0;
        chk("cfg", {b.exp_key, b.exp_n}, {24'd103, 24'd143});
        for (int i = 0; i < 9; i++) begin
            push(v[i].ct);
            if (v[i].drop) expect_drop($sformatf("vec%0d", i));
            else get(v[i].pt, $sformatf("vec%0d", i));
        end
        push(12'd48);
        n = 0;
        while (!b.exp_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", {b.exp_start, n <= 2}, 2'b11);
        get(12'd9, "lat_pt");
        stall = 1'b1;
        push(12'd48);
        n = 0;
        while (!b.exp_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("burst_run", b.exp_start, 1);
        push(12'd128);
        push(12'd42);
        push(12'd1);
        push(12'd142);
        chk("full_ready", b.ct_ready, 0);
        b.cfg_load = 1'b1;
        b.key_in = 24'd5;
        b.n_in = 24'd7;
        @(negedge clk);
        b.cfg_load = 1'b0;
        chk("cfg_ignored", {b.exp_key, b.exp_n}, {24'd103, 24'd143});
        b.ct_valid = 1'b1;
        b.ct_data = 12'd0;
        acc = 0;
        repeat (3) begin
            acc |= int'(b.ct_ready);
            @(negedge clk);
        end
        chk("fifth_refused", acc, 0);
        stall = 1'b0;
        fork
            push(12'd0);
        join_none
        get(12'd9, "burst0");
        get(12'd2, "burst1");
        get(12'd3, "burst2");
        get(12'd1, "burst3");
        get(12'd142, "burst4");
        get(12'd0, "burst_fullpush");
        push(12'd48);
        push(12'd128);
        n = 0;
        while (!b.pt_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        repeat (20) begin
            bad += int'(!b.pt_valid || b.pt_data != 12'd9 || b.exp_start);
            @(negedge clk);
        end
        chk("hold_stable", bad, 0);
        get(12'd9, "hold0");
        get(12'd2, "hold1");
        hold = 1'b1;
        push(12'd42);
        get(12'd3, "drain_pt");
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            bad += int'(!b.busy || b.exp_start || b.pt_valid);
        end
        chk("drain_wait", bad, 0);
        hold = 1'b0;
        repeat (3) @(negedge clk);
        chk("drain_idle", b.busy, 0);
        stall = 1'b1;
        push(12'd48);
        run_n = 0;
        ps = 0;
        n = 0;
        while (!b.err && n < 200) begin
            run_n += int'(b.exp_start);
            ps += int'(b.pt_valid);
            @(negedge clk);
            n++;
        end
        chk("timeout_err", b.err, 1);
        chk("timeout_cycles", run_n, 40);
        chk("timeout_nopt", ps, 0);
        @(negedge clk);
        chk("timeout_idle", {b.err, b.busy}, 2'b00);
        push(12'd48);
        n = 0;
        while (!b.exp_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_run", b.exp_start, 1);
        push(12'd128);
        push(12'd42);
        push(12'd1);
        rst = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            bad += int'(b.pt_valid || b.busy || !b.ct_ready);
        end
        chk("after_rst", bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
